posit_dot_stream: RTL and testbench

Parametrised, pipelined posit<N,0> dot-product engine with valid/ready streaming on both sides. Each beat supplies one operand pair; products accumulate exactly in an internal fixed-point quire. The result is rounded once to a posit when the beat flagged `in_last` retires. It is the next-generation successor of the 8-bit single-step MAC: no per-step rounding, any width N, vector-framed, with backpressure.

---
 rtl/posit_dot_stream.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_posit_dot_stream.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/posit_dot_stream.sv
// posit_dot_stream: pipelined posit<N,0> dot product over an exact quire.
// Define POSIT_DOT_ACC_INIT_EN to add the in_c vector seed port (a*b+c).
module posit_dot_stream #(
  parameter int N          = 8,
  parameter int CARRY_BITS = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic [15:0]  out_count
`ifdef POSIT_DOT_ACC_INIT_EN
  ,
  input  logic [N-1:0] in_c
`endif
);
  localparam int QW = 4*N - 6 + CARRY_BITS;
  localparam int PW = 2*N - 4;
  localparam int WW = 6*N - 12;
  localparam int FW = N - 3;

  localparam logic [1:0] ACCUM  = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] OUTPUT = 2'd2;

  typedef struct packed {
    logic          zero;
    logic          nar;
    logic          sgn;
    logic [7:0]    k;
    logic [FW-1:0] frac;
  } dec_t;

  function automatic dec_t decode(input logic [N-1:0] x);
    dec_t       d;
    logic [N-1:0] u;
    logic       r;
    logic       run;
    int         m;
    d.zero = (x == '0);
    d.nar  = (x == {1'b1, {(N-1){1'b0}}});
    d.sgn  = x[N-1];
    u      = x[N-1] ? (~x + 1'b1) : x;
    r      = u[N-2];
    run    = 1'b1;
    m      = 0;
    for (int i = N-2; i >= 0; i--) begin
      if (run && (u[i] == r)) m++;
      else run = 1'b0;
    end
    d.k    = r ? 8'(m - 1) : 8'(-m);
    u      = u << (m - 1);
    d.frac = u[FW-1:0];
    return d;
  endfunction

  // product lands in quire units of 2^-(2N-4); shift is biased to stay >= 0
  function automatic logic [QW-1:0] prod_term(input dec_t a, input dec_t b);
    logic [PW-1:0] p;
    logic [WW-1:0] w;
    logic [QW-1:0] t;
    int            sh;
    p  = PW'({1'b1, a.frac}) * PW'({1'b1, b.frac});
    sh = int'($signed(a.k)) + int'($signed(b.k)) + PW;
    w  = WW'(p) << sh;
    t  = QW'(w >> (2*N - 6));
    if (a.zero || b.zero || a.nar || b.nar) t = '0;
    else if (a.sgn ^ b.sgn) t = ~t + 1'b1;
    return t;
  endfunction

`ifdef POSIT_DOT_ACC_INIT_EN
  function automatic logic [QW-1:0] seed_term(input dec_t c);
    logic [QW-1:0] t;
    t = QW'({1'b1, c.frac}) << (int'($signed(c.k)) + N - 1);
    if (c.zero || c.nar) t = '0;
    else if (c.sgn) t = ~t + 1'b1;
    return t;
  endfunction
`endif

  function automatic logic [N-1:0] encode(
    input logic [QW-1:0] q,
    input logic          nar
  );
    logic [QW-1:0] mag;
    logic [QW-1:0] frac;
    logic [N:0]    rv;
    logic [N+QW:0] c;
    logic [N-2:0]  body;
    logic [N-1:0]  pos;
    logic [N-1:0]  res;
    logic          rnd;
    int            p, k, m;
    mag = q[QW-1] ? (~q + 1'b1) : q;
    p   = 0;
    for (int i = 0; i < QW; i++) begin
      if (mag[i]) p = i;
    end
    k    = p - PW;
    frac = mag << (QW - p);
    if (k >= 0) m = k + 1;
    else m = -k;
    if (m > N - 1) m = N - 1;
    if (k >= 0) rv = (N+1)'(((1 << m) - 1) << 1);
    else rv = (N+1)'(1);
    // regime then fraction, left-aligned; the tail feeds guard/sticky
    c    = {rv, frac} << (N - m);
    body = c[N+QW -: N-1];
    rnd  = c[QW+1] && ((|c[QW:0]) || body[0]);
    if (k > N - 2) pos = {1'b0, {(N-1){1'b1}}};
    else if (k < 2 - N) pos = {{(N-1){1'b0}}, 1'b1};
    else pos = {1'b0, body + {{(N-2){1'b0}}, rnd}};
    res = q[QW-1] ? (~pos + 1'b1) : pos;
    if (q == '0) res = '0;
    if (nar) res = {1'b1, {(N-1){1'b0}}};
    return res;
  endfunction

  logic [1:0]    state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          p_valid_q, p_valid_d;
  logic          p_last_q, p_last_d;
  logic          p_nar_q, p_nar_d;
  logic [QW-1:0] p_term_q, p_term_d;
  logic [QW-1:0] acc_q, acc_d;
  logic          nar_q, nar_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          e_valid_q, e_valid_d;
  logic          e_nar_q, e_nar_d;
  logic [QW-1:0] e_acc_q, e_acc_d;
  logic [15:0]   e_cnt_q, e_cnt_d;
  logic          r_valid_q, r_valid_d;
  logic [N-1:0]  r_res_q, r_res_d;
  logic [15:0]   r_cnt_q, r_cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_result_q, out_result_d;
  logic [15:0]   out_count_q, out_count_d;

  dec_t          da, db;
  logic          accept;
  logic [QW-1:0] seed;
  logic          seed_nar;
  logic [QW-1:0] sum;
  logic [15:0]   cnt_inc;

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_count  = out_count_q;
  assign accept     = in_valid && in_ready_q;
  assign da         = decode(in_a);
  assign db         = decode(in_b);

`ifdef POSIT_DOT_ACC_INIT_EN
  dec_t dc;
  logic first_q, first_d;
  assign dc = decode(in_c);

  always_comb begin
    seed     = first_q ? seed_term(dc) : '0;
    seed_nar = first_q && dc.nar;
    first_d  = accept ? in_last : first_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) first_q <= 1'b1;
    else first_q <= first_d;
  end
`else
  always_comb begin
    seed     = '0;
    seed_nar = 1'b0;
  end
`endif

  always_comb begin
    p_valid_d = accept;
    p_last_d  = p_last_q;
    p_nar_d   = p_nar_q;
    p_term_d  = p_term_q;
    if (accept) begin
      p_last_d = in_last;
      p_nar_d  = da.nar || db.nar || seed_nar;
      p_term_d = prod_term(da, db) + seed;
    end
  end

  always_comb begin
    sum       = acc_q + p_term_q;
    cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    acc_d     = acc_q;
    nar_d     = nar_q;
    cnt_d     = cnt_q;
    e_valid_d = 1'b0;
    e_acc_d   = e_acc_q;
    e_nar_d   = e_nar_q;
    e_cnt_d   = e_cnt_q;
    if (p_valid_q) begin
      if (p_last_q) begin
        e_valid_d = 1'b1;
        e_acc_d   = sum;
        e_nar_d   = nar_q || p_nar_q;
        e_cnt_d   = cnt_inc;
        acc_d     = '0;
        nar_d     = 1'b0;
        cnt_d     = '0;
      end else begin
        acc_d = sum;
        nar_d = nar_q || p_nar_q;
        cnt_d = cnt_inc;
      end
    end
  end

  always_comb begin
    r_valid_d    = e_valid_q;
    r_res_d      = r_res_q;
    r_cnt_d      = r_cnt_q;
    if (e_valid_q) begin
      r_res_d = encode(e_acc_q, e_nar_q);
      r_cnt_d = e_cnt_q;
    end
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_count_d  = out_count_q;
    if (r_valid_q) begin
      out_valid_d  = 1'b1;
      out_result_d = r_res_q;
      out_count_d  = r_cnt_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == ACCUM):  if (accept && in_last) state_d = DRAIN;
      (state_q == DRAIN):  if (r_valid_q) state_d = OUTPUT;
      (state_q == OUTPUT): if (out_valid_q && out_ready) state_d = ACCUM;
      default:             state_d = ACCUM;
    endcase
    in_ready_d = (state_d == ACCUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACCUM;
      in_ready_q   <= 1'b0;
      p_valid_q    <= 1'b0;
      p_last_q     <= 1'b0;
      p_nar_q      <= 1'b0;
      p_term_q     <= '0;
      acc_q        <= '0;
      nar_q        <= 1'b0;
      cnt_q        <= '0;
      e_valid_q    <= 1'b0;
      e_nar_q      <= 1'b0;
      e_acc_q      <= '0;
      e_cnt_q      <= '0;
      r_valid_q    <= 1'b0;
      r_res_q      <= '0;
      r_cnt_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      p_valid_q    <= p_valid_d;
      p_last_q     <= p_last_d;
      p_nar_q      <= p_nar_d;
      p_term_q     <= p_term_d;
      acc_q        <= acc_d;
      nar_q        <= nar_d;
      cnt_q        <= cnt_d;
      e_valid_q    <= e_valid_d;
      e_nar_q      <= e_nar_d;
      e_acc_q      <= e_acc_d;
      e_cnt_q      <= e_cnt_d;
      r_valid_q    <= r_valid_d;
      r_res_q      <= r_res_d;
      r_cnt_q      <= r_cnt_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_count_q  <= out_count_d;
    end
  end

endmodule

// File: tb/tb_posit_dot_stream.sv
// tb_posit_dot_stream: directed posit8 vectors checked against a
// scoreboard of expected results and term counts.
module tb_posit_dot_stream;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_result;
  logic [15:0]  out_count;
`ifdef POSIT_DOT_ACC_INIT_EN
  logic [N-1:0] in_c;
`endif

  typedef struct {
    logic [N-1:0] res;
    logic [15:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  posit_dot_stream #(.N(N), .CARRY_BITS(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_count  (out_count)
`ifdef POSIT_DOT_ACC_INIT_EN
    ,
    .in_c       (in_c)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [N-1:0] r, input logic [15:0] c);
    exp_t e;
    e.res = r;
    e.cnt = c;
    sb.push_back(e);
  endtask

  // called at a negedge; returns at the negedge after the handshake edge
  task automatic beat(input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic last);
    int w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = 8'($urandom);
    in_b     = 8'($urandom);
    in_last  = 1'b0;
  endtask

  task automatic get_result(input string tag, input bit lat);
    exp_t e;
    int   w = 0;
    while (out_valid !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_valid"}, out_valid, 1);
    if (lat) chk({tag, "_latency"}, w, 3);
    chk({tag, "_sb"}, (sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_res"}, out_result, e.res);
      chk({tag, "_cnt"}, out_count, e.cnt);
    end
    if (out_ready) @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
`ifdef POSIT_DOT_ACC_INIT_EN
    in_c      = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_count", out_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);

    // 1*1 + 2*2 = 5
    push(8'h72, 16'd2);
    beat(8'h40, 8'h40, 1'b0);
    beat(8'h60, 8'h60, 1'b1);
    chk("drain_in_ready", in_ready, 0);
    get_result("sum5", 1'b1);
    chk("bubble_in_ready", in_ready, 1);
    chk("bubble_out_valid", out_valid, 0);

    // 64 + 1/64 - 64 stays exact
    push(8'h01, 16'd3);
    beat(8'h7F, 8'h40, 1'b0);
    beat(8'h01, 8'h40, 1'b0);
    beat(8'h81, 8'h40, 1'b1);
    get_result("exact", 1'b1);

    push(8'h80, 16'd3);
    beat(8'h40, 8'h40, 1'b0);
    beat(8'h80, 8'h20, 1'b0);
    beat(8'h60, 8'h40, 1'b1);
    get_result("nar", 1'b0);

    push(8'h20, 16'd1);
    beat(8'h20, 8'h40, 1'b1);
    get_result("nar_clr", 1'b0);

    push(8'h7F, 16'd2);
    beat(8'h7F, 8'h7F, 1'b0);
    beat(8'h7F, 8'h7F, 1'b1);
    get_result("maxpos", 1'b0);

    push(8'h01, 16'd1);
    beat(8'h01, 8'h01, 1'b1);
    get_result("minpos", 1'b0);

    push(8'h81, 16'd1);
    beat(8'h81, 8'h7F, 1'b1);
    get_result("neg_max", 1'b0);

    // exact tie 1 + 1/64: even neighbour is 1.0
    push(8'h40, 16'd2);
    beat(8'h40, 8'h40, 1'b0);
    beat(8'h01, 8'h40, 1'b1);
    get_result("tie_even", 1'b0);

    // exact tie 1 + 3/64: rounds up to even 1 + 2/32
    push(8'h42, 16'd2);
    beat(8'h41, 8'h40, 1'b0);
    beat(8'h01, 8'h40, 1'b1);
    get_result("tie_up", 1'b0);

    push(8'hA0, 16'd1);
    beat(8'hC0, 8'h60, 1'b1);
    get_result("neg_two", 1'b0);

    out_ready = 1'b0;
    push(8'h60, 16'd1);
    beat(8'h40, 8'h60, 1'b1);
    get_result("bp", 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_res", out_result, 8'h60);
      chk("bp_hold_cnt", out_count, 16'd1);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_in_ready", in_ready, 1);
    chk("bp_rel_valid", out_valid, 0);

    beat(8'h40, 8'h40, 1'b0);
    beat(8'h60, 8'h60, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
`ifdef POSIT_DOT_ACC_INIT_EN
    in_c = 8'h60;
    push(8'h40, 16'd1);
`else
    push(8'hC0, 16'd1);
`endif
    beat(8'h40, 8'hC0, 1'b1);
`ifdef POSIT_DOT_ACC_INIT_EN
    in_c = '0;
`endif
    get_result("after_rst", 1'b1);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
